// File: rtl/load_store_unit.sv
// Memory-access stage that sits after the ALU. It captures one load or store
// request, validates it, drives a ready-handshaked data-memory port and returns
// the extended load data. The core is stalled while the access is outstanding.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  output logic        stall,
  output logic        done,
  output logic [31:0] readData,
  output logic        misaligned,
  output logic        illegal,
  output logic        busError,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWdata,
  output logic [3:0]  memBe,
  input  logic        memReady,
  input  logic [31:0] memRdata
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIM = CNT_WIDTH'(TIMEOUT_CYCLES);

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [31:0]          addr_q, addr_d;
  logic [1:0]           off_q, off_d;
  logic [2:0]           f3_q, f3_d;
  logic                 we_q, we_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           be_q, be_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 mis_q, mis_d;
  logic                 ill_q, ill_d;
  logic                 berr_q, berr_d;

  logic                 req_valid;
  logic                 req_illegal;
  logic                 req_misaligned;
  logic [3:0]           fmt_be;
  logic [31:0]          fmt_wdata;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [31:0]          load_val;
  logic [CNT_WIDTH-1:0] cnt_inc;

  // Decode the incoming request: legality, alignment and store lane formatting.
  always_comb begin
    req_valid      = start & (memRead | memWrite);
    req_illegal    = (memRead & memWrite)
                   | (memWrite & funct3[2])
                   | (funct3 == 3'b011)
                   | (funct3[2] & funct3[1]);
    req_misaligned = ((funct3[1:0] == 2'b01) & aluResult[0])
                   | ((funct3 == 3'b010) & (aluResult[1:0] != 2'b00));
    case (funct3[1:0])
      2'b00: begin
        fmt_be    = 4'b0001 << aluResult[1:0];
        fmt_wdata = {4{writeData[7:0]}};
      end
      2'b01: begin
        fmt_be    = aluResult[1] ? 4'b1100 : 4'b0011;
        fmt_wdata = {2{writeData[15:0]}};
      end
      default: begin
        fmt_be    = 4'b1111;
        fmt_wdata = writeData;
      end
    endcase
  end

  // Pick the addressed byte/half out of the returned word and extend it.
  always_comb begin
    byte_sel = memRdata[{off_q, 3'b000} +: 8];
    half_sel = memRdata[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_val = {24'd0, byte_sel};
      3'b101:  load_val = {16'd0, half_sel};
      default: load_val = memRdata;
    endcase
  end

  // Access sequencing: capture in IDLE, handshake in REQ, one-cycle report in RESP.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    f3_d    = f3_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    ill_d   = ill_q;
    berr_d  = berr_q;
    cnt_inc = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d  = {aluResult[31:2], 2'b00};
          off_d   = aluResult[1:0];
          f3_d    = funct3;
          we_d    = memWrite;
          wdata_d = fmt_wdata;
          be_d    = fmt_be;
          cnt_d   = '0;
          if (req_illegal) begin
            ill_d   = 1'b1;
            state_d = S_RESP;
          end else if (req_misaligned) begin
            mis_d   = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (memReady) begin
          if (!we_q) rdata_d = load_val;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_inc;
          // A zero limit means wait for the bus forever.
          if ((TIMEOUT_CYCLES != 0) && (cnt_inc == TIMEOUT_LIM)) begin
            berr_d  = 1'b1;
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        mis_d   = 1'b0;
        ill_d   = 1'b0;
        berr_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      off_q   <= '0;
      f3_q    <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      ill_q   <= 1'b0;
      berr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      f3_q    <= f3_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      ill_q   <= ill_d;
      berr_q  <= berr_d;
    end
  end

  // The stall covers the request cycle itself so the core holds its PC immediately.
  assign stall      = ((state_q == S_IDLE) & start & (memRead | memWrite)) | (state_q == S_REQ);
  assign done       = (state_q == S_RESP);
  assign memReq     = (state_q == S_REQ);
  assign memWe      = we_q & (state_q == S_REQ);
  assign memAddr    = addr_q;
  assign memWdata   = wdata_q;
  assign memBe      = be_q;
  assign readData   = rdata_q;
  assign misaligned = mis_q;
  assign illegal    = ill_q;
  assign busError   = berr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a transaction-level model predicts the
// per-cycle outputs, one negedge process compares them, and literal checks pin
// the model to hand-computed values.
module tb_load_store_unit;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset, start, memRead, memWrite, memReady;
  logic [2:0]  funct3;
  logic [31:0] aluResult, writeData, memRdata;
  logic        stall, done, misaligned, illegal, busError, memReq, memWe;
  logic [31:0] readData, memAddr, memWdata;
  logic [3:0]  memBe;

  load_store_unit #(.TIMEOUT_CYCLES(TO), .CNT_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .start(start), .memRead(memRead), .memWrite(memWrite),
    .funct3(funct3), .aluResult(aluResult), .writeData(writeData),
    .stall(stall), .done(done), .readData(readData),
    .misaligned(misaligned), .illegal(illegal), .busError(busError),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memBe(memBe), .memReady(memReady), .memRdata(memRdata)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // Expected per-cycle outputs, maintained by the stimulus tasks.
  logic        chk_en = 1'b0;
  logic        e_stall, e_done, e_req, e_we, e_mis, e_ill, e_berr;
  logic [31:0] e_addr, e_wdata, e_rd;
  logic [3:0]  e_be;

  // Observations gathered over one transaction for the literal checks.
  int          cyc, n_stall, n_req, n_done, done_at;
  logic [3:0]  seen_be;
  logic [31:0] seen_wdata, seen_addr;
  logic        seen_mis, seen_ill, seen_berr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Model: access size in bytes.
  function automatic int m_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 1;
      2'b01:   return 2;
      default: return 4;
    endcase
  endfunction

  // Model: byte lanes touched by an access of n bytes at the aligned base.
  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int n, base;
    logic [3:0] be;
    n = m_size(f3);
    base = (int'(addr[1:0]) / n) * n;
    for (int i = 0; i < 4; i++) be[i] = (i >= base) && (i < base + n);
    return be;
  endfunction

  // Model: store data replicated into every lane.
  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n;
    logic [31:0] w;
    n = m_size(f3);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = wd[8*(i % n) +: 8];
    return w;
  endfunction

  // Model: load value shifted down from its lane, masked, and extended.
  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] addr,
                                         input logic [31:0] rdat);
    int n;
    logic [31:0] v;
    n = m_size(f3);
    v = rdat >> (8 * int'(addr[1:0]));
    if (n == 1) begin
      v = v & 32'h0000_00FF;
      if (!f3[2] && v[7]) v = v | 32'hFFFF_FF00;
    end else if (n == 2) begin
      v = v & 32'h0000_FFFF;
      if (!f3[2] && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    cyc = 0; n_stall = 0; n_req = 0; n_done = 0; done_at = -1;
    seen_be = '0; seen_wdata = '0; seen_addr = '0;
    seen_mis = 0; seen_ill = 0; seen_berr = 0;
  endtask

  // Single compare process: every cycle against the model expectations.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall", 32'(stall), 32'(e_stall));
      chk("done", 32'(done), 32'(e_done));
      chk("memReq", 32'(memReq), 32'(e_req));
      chk("misaligned", 32'(misaligned), 32'(e_mis));
      chk("illegal", 32'(illegal), 32'(e_ill));
      chk("busError", 32'(busError), 32'(e_berr));
      chk("readData", readData, e_rd);
      if (e_req) begin
        chk("memAddr", memAddr, e_addr);
        chk("memWe", 32'(memWe), 32'(e_we));
        chk("memBe", 32'(memBe), 32'(e_be));
        if (e_we) chk("memWdata", memWdata, e_wdata);
      end
      if (stall) n_stall++;
      if (memReq) begin
        n_req++;
        seen_be = memBe; seen_wdata = memWdata; seen_addr = memAddr;
      end
      if (done) begin
        n_done++;
        done_at = cyc;
        seen_mis = misaligned; seen_ill = illegal; seen_berr = busError;
      end
      cyc++;
    end
  end

  // One access; ready_at is the REQ cycle index carrying memReady (-1: never).
  task automatic access(input string name, input logic rd, input logic wr,
                        input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rdat, input int ready_at);
    bit ill, mis, fin, ok;
    int n, c;
    n   = m_size(f3);
    ill = (rd && wr) || (f3 inside {3'b011, 3'b110, 3'b111}) || (wr && (f3 inside {3'b100, 3'b101}));
    mis = !ill && ((int'(addr[1:0]) % n) != 0);
    clear_obs();
    start = 1; memRead = rd; memWrite = wr; funct3 = f3; aluResult = addr; writeData = wd;
    memReady = 0; memRdata = rdat;
    e_stall = 1; e_req = 0; e_done = 0; e_mis = 0; e_ill = 0; e_berr = 0;
    step();
    start = 0; memRead = 0; memWrite = 0;
    if (ill || mis) begin
      e_stall = 0; e_done = 1; e_ill = ill; e_mis = mis;
      step();
    end else begin
      e_req = 1; e_stall = 1; e_addr = {addr[31:2], 2'b00}; e_we = wr;
      e_be = m_be(f3, addr); e_wdata = m_wdata(f3, wd);
      c = 1; fin = 0; ok = 0;
      while (!fin) begin
        memReady = (c == ready_at);
        step();
        if (c == ready_at) begin fin = 1; ok = 1; end
        else if (c >= TO) fin = 1;
        c++;
      end
      memReady = 0;
      e_req = 0; e_stall = 0; e_done = 1; e_berr = !ok;
      if (ok && rd) e_rd = m_load(f3, addr, rdat);
      step();
    end
    e_done = 0; e_mis = 0; e_ill = 0; e_berr = 0;
    step();
    $display("txn %s addr=%h rd=%0d wr=%0d f3=%b done_at=%0d readData=%h flags m/i/b=%0d%0d%0d",
             name, addr, rd, wr, f3, done_at, readData, seen_mis, seen_ill, seen_berr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; start = 0; memRead = 0; memWrite = 0; funct3 = 0;
    aluResult = 0; writeData = 0; memReady = 0; memRdata = 0;
    e_stall = 0; e_done = 0; e_req = 0; e_we = 0; e_mis = 0; e_ill = 0; e_berr = 0;
    e_addr = 0; e_wdata = 0; e_rd = 0; e_be = 0;
    clear_obs();
    step(); step();
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_memReq", 32'(memReq), 32'd0);
    chk("rst_memWe", 32'(memWe), 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memWdata", memWdata, 32'd0);
    chk("rst_memBe", 32'(memBe), 32'd0);
    chk("rst_readData", readData, 32'd0);
    chk("rst_flags", {29'd0, misaligned, illegal, busError}, 32'd0);
    reset = 0;
    chk_en = 1;
    step();

    access("SW", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 1);
    chk("sw_be", 32'(seen_be), 32'hF);
    chk("sw_addr", seen_addr, 32'h100);
    chk("sw_done_at", 32'(done_at), 32'd2);

    access("LW", 1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 1);
    chk("lw_data", readData, 32'hDEADBEEF);

    access("LB", 1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 1);
    chk("lb_data", readData, 32'hFFFFFF80);

    access("LBU", 1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF_0000, 1);
    chk("lbu_data", readData, 32'h00000080);
    chk("lbu_be", 32'(seen_be), 32'h8);

    access("SH", 0, 1, 3'b001, 32'h102, 32'h1234ABCD, 32'h0, 1);
    chk("sh_wdata", seen_wdata, 32'hABCDABCD);
    chk("sh_be", 32'(seen_be), 32'hC);

    access("SB", 0, 1, 3'b000, 32'h101, 32'h0000_0055, 32'h0, 2);
    chk("sb_wdata", seen_wdata, 32'h55555555);
    chk("sb_be", 32'(seen_be), 32'h2);

    access("LH", 1, 0, 3'b001, 32'h102, 32'h0, 32'h8001_0000, 1);
    chk("lh_data", readData, 32'hFFFF8001);

    access("LHU", 1, 0, 3'b101, 32'h102, 32'h0, 32'h8001_0000, 1);
    chk("lhu_data", readData, 32'h00008001);

    access("LH_mis", 1, 0, 3'b001, 32'h101, 32'h0, 32'hFFFF_FFFF, 1);
    chk("mis_flag", 32'(seen_mis), 32'd1);
    chk("mis_done_at", 32'(done_at), 32'd1);
    chk("mis_noreq", 32'(n_req), 32'd0);
    chk("mis_rd_hold", readData, 32'h00008001);

    access("RW_ill", 1, 1, 3'b010, 32'h100, 32'h0, 32'h0, 1);
    chk("ill_flag", 32'(seen_ill), 32'd1);
    chk("ill_mis_clear", 32'(seen_mis), 32'd0);

    access("SBU_ill", 0, 1, 3'b100, 32'h100, 32'h0, 32'h0, 1);
    chk("sbu_ill", 32'(seen_ill), 32'd1);

    access("LW_slow", 1, 0, 3'b010, 32'h200, 32'h0, 32'h11223344, 3);
    chk("slow_stall_cnt", 32'(n_stall), 32'd4);
    chk("slow_done_cnt", 32'(n_done), 32'd1);
    chk("slow_data", readData, 32'h11223344);

    access("SW_timeout", 0, 1, 3'b010, 32'h300, 32'hA5A5A5A5, 32'h0, -1);
    chk("to_berr", 32'(seen_berr), 32'd1);
    chk("to_req_cycles", 32'(n_req), 32'(TO));
    chk("to_rd_hold", readData, 32'h11223344);

    // Reset pulsed in the second REQ cycle of a load.
    clear_obs();
    start = 1; memRead = 1; memWrite = 0; funct3 = 3'b010; aluResult = 32'h400;
    e_stall = 1; e_req = 0; e_done = 0;
    step();
    start = 0; memRead = 0;
    e_req = 1; e_stall = 1; e_addr = 32'h400; e_we = 0; e_be = 4'hF;
    step();
    reset = 1;
    step();
    reset = 0;
    e_req = 0; e_stall = 0; e_rd = 32'h0;
    chk("rst_mid_memReq", 32'(memReq), 32'd0);
    step(); step();
    chk("rst_mid_nodone", 32'(n_done), 32'd0);
    $display("txn RESET_mid_REQ addr=00000400 done_count=%0d memReq=%0d", n_done, memReq);

    access("LW_after_rst", 1, 0, 3'b010, 32'h400, 32'h0, 32'hCAFEF00D, 1);
    chk("post_rst_data", readData, 32'hCAFEF00D);
    chk("post_rst_done", 32'(n_done), 32'd1);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
